// File: rtl/ext_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode codes and
// the skid-buffer state encoding.
package ext_pkg;

  localparam logic [1:0] EXT_SEXT   = 2'b00;
  localparam logic [1:0] EXT_ZEXT   = 2'b01;
  localparam logic [1:0] EXT_UPPER  = 2'b10;
  localparam logic [1:0] EXT_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/ext_pipe_unit_if.sv
// Valid/ready bundle between the instruction register side (master) and
// the extension unit (slave).
interface ext_pipe_unit_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [1:0]       out_mode;

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_mode
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_mode
  );

endinterface

// File: rtl/ext_skid_buf.sv
// Generic 2-entry valid/ready skid buffer. M drives the outputs; S absorbs
// the one extra transfer that slips in while in_ready is still registered high.
module ext_skid_buf
  import ext_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state;
  logic         m_valid;
  logic         s_valid;
  logic [W-1:0] m_data;
  logic [W-1:0] s_data;
  logic         in_fire;
  logic         out_fire;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = m_valid && out_ready;
  assign out_valid = m_valid;
  assign out_data  = m_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SKID_EMPTY;
      m_valid  <= 1'b0;
      s_valid  <= 1'b0;
      m_data   <= '0;
      s_data   <= '0;
      in_ready <= 1'b1;
    end else begin
      case (state)
        SKID_EMPTY: begin
          if (in_fire) begin
            m_data  <= in_data;
            m_valid <= 1'b1;
            state   <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (in_fire && out_fire) begin
            m_data <= in_data;
          end else if (in_fire) begin
            s_data   <= in_data;
            s_valid  <= 1'b1;
            in_ready <= 1'b0;
            state    <= SKID_FULL;
          end else if (out_fire) begin
            m_valid <= 1'b0;
            state   <= SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          // in_ready is low here, so only the drain of M can happen
          if (out_fire) begin
            m_data   <= s_data;
            s_valid  <= 1'b0;
            in_ready <= 1'b1;
            state    <= SKID_ONE;
          end
        end
        default: begin
          state    <= SKID_EMPTY;
          m_valid  <= 1'b0;
          s_valid  <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ext_pipe_unit.sv
// Pipelined immediate extender: combinational SEXT/ZEXT/UPPER/BRANCH
// extension feeding a registered skid buffer that carries {mode, data}.
module ext_pipe_unit
  import ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic            clk,
  input  logic            rst,
  ext_pipe_unit_if.slave  bus
);

  if (IN_W < 2) begin : g_bad_in_w
    $error("ext_pipe_unit: IN_W must be at least 2");
  end
  if (OUT_W < IN_W + BR_SHIFT) begin : g_bad_out_w
    $error("ext_pipe_unit: OUT_W must be at least IN_W + BR_SHIFT");
  end

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W+1:0] in_payload;
  logic [OUT_W+1:0] out_payload;

  // Casts keep this legal even when OUT_W == IN_W (no zero-width replication)
  assign sext   = OUT_W'($signed(bus.in_imm));
  assign zext   = OUT_W'(bus.in_imm);
  assign upper  = zext << (OUT_W - IN_W);
  assign branch = sext << BR_SHIFT;

  always_comb begin
    ext_data = sext;
    case (bus.in_mode)
      EXT_SEXT:   ext_data = sext;
      EXT_ZEXT:   ext_data = zext;
      EXT_UPPER:  ext_data = upper;
      EXT_BRANCH: ext_data = branch;
      default:    ext_data = sext;
    endcase
  end

  assign in_payload = {bus.in_mode, ext_data};

  ext_skid_buf #(
    .W(OUT_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_payload),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_payload)
  );

  assign bus.out_data = out_payload[OUT_W-1:0];
  assign bus.out_mode = out_payload[OUT_W+1:OUT_W];

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Scoreboard bench for ext_pipe_unit: default 16->32 instance plus a
// 12->20, shift-1 instance for the parameter sweep.
module tb_ext_pipe_unit;
  import ext_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  logic [33:0] sb[$];

  ext_pipe_unit_if #(.IN_W(16), .OUT_W(32)) bus_d ();
  ext_pipe_unit_if #(.IN_W(12), .OUT_W(20)) bus_s ();

  ext_pipe_unit #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  ext_pipe_unit #(.IN_W(12), .OUT_W(20), .BR_SHIFT(1)) u_sweep (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [33:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
    logic [31:0] r;
    case (mode)
      2'b00:   r = {{16{imm[15]}}, imm};
      2'b01:   r = {16'h0000, imm};
      2'b10:   r = {imm, 16'h0000};
      default: r = {{14{imm[15]}}, imm, 2'b00};
    endcase
    return {mode, r};
  endfunction

  // One cycle on the default instance: sample at negedge, drive, then
  // update the scoreboard for the transfers that happen at the next posedge.
  task automatic drive_cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                             input logic ordy, output logic fired, output logic [33:0] exp,
                             output logic [33:0] act, output logic rdy, output logic ov);
    @(negedge clk);
    rdy = bus_d.in_ready;
    ov  = bus_d.out_valid;
    act = {bus_d.out_mode, bus_d.out_data};
    bus_d.in_valid  = v;
    bus_d.in_imm    = imm;
    bus_d.in_mode   = mode;
    bus_d.out_ready = ordy;
    fired = ov && ordy;
    exp   = 'x;
    if (fired && sb.size() > 0) exp = sb.pop_front();
    if (v && rdy) sb.push_back(ref_ext(imm, mode));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_d.out_valid !== 1'b0 || bus_d.in_ready !== 1'b1) $display("[TB] FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", bus_d.out_valid, bus_d.in_ready);
    else passes++;
    checks++;
    if (bus_d.out_data !== 32'h0 || bus_d.out_mode !== 2'b00) $display("[TB] FAIL reset_data: out_data=%h out_mode=%b, required 0/0", bus_d.out_data, bus_d.out_mode);
    else passes++;
    checks++;
    if (bus_s.out_valid !== 1'b0 || bus_s.in_ready !== 1'b1 || bus_s.out_data !== 20'h0) $display("[TB] FAIL reset_sweep: out_valid=%b in_ready=%b out_data=%h, required 0/1/0", bus_s.out_valid, bus_s.in_ready, bus_s.out_data);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_modes();
    logic [15:0] imms [5] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0001};
    logic [1:0]  modes[5] = '{EXT_SEXT, EXT_ZEXT, EXT_UPPER, EXT_BRANCH, EXT_BRANCH};
    logic [31:0] want [5] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC, 32'h00000004};
    logic fired, rdy, ov;
    logic [33:0] exp, act;
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) drive_cycle(1'b1, imms[i], modes[i], 1'b1, fired, exp, act, rdy, ov);
      else       drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
      if (i > 0) begin
        checks++;
        if (!fired || act[31:0] !== want[i-1] || act !== exp)
          $display("[TB] FAIL mode_%0d: got valid=%b data=%h mode=%b, required data=%h mode=%b one cycle after acceptance", i-1, ov, act[31:0], act[33:32], want[i-1], modes[i-1]);
        else passes++;
      end
    end
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
  endtask

  task automatic test_backpressure();
    logic fired, rdy, ov;
    logic [33:0] exp, act;
    drive_cycle(1'b1, 16'h0001, EXT_SEXT, 1'b0, fired, exp, act, rdy, ov);
    drive_cycle(1'b1, 16'h0002, EXT_SEXT, 1'b0, fired, exp, act, rdy, ov);
    checks++;
    if (rdy !== 1'b1) $display("[TB] FAIL bp_second_accept: in_ready=%b, required 1", rdy);
    else passes++;
    drive_cycle(1'b1, 16'h0003, EXT_SEXT, 1'b0, fired, exp, act, rdy, ov);
    checks++;
    if (rdy !== 1'b0) $display("[TB] FAIL bp_ready_low: in_ready=%b, required 0", rdy);
    else passes++;
    drive_cycle(1'b1, 16'h0003, EXT_SEXT, 1'b0, fired, exp, act, rdy, ov);
    checks++;
    if (ov !== 1'b1 || act !== {EXT_SEXT, 32'h00000001} || rdy !== 1'b0)
      $display("[TB] FAIL bp_hold: valid=%b data=%h in_ready=%b, required 1/00000001/0", ov, act[31:0], rdy);
    else passes++;
    drive_cycle(1'b1, 16'h0003, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (!fired || act !== exp || act[31:0] !== 32'h1) $display("[TB] FAIL bp_out1: data=%h fired=%b, required 00000001", act[31:0], fired);
    else passes++;
    drive_cycle(1'b1, 16'h0003, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (rdy !== 1'b1 || !fired || act !== exp || act[31:0] !== 32'h2)
      $display("[TB] FAIL bp_out2: in_ready=%b data=%h, required 1/00000002", rdy, act[31:0]);
    else passes++;
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (!fired || act !== exp || act[31:0] !== 32'h3) $display("[TB] FAIL bp_out3: data=%h fired=%b, required 00000003", act[31:0], fired);
    else passes++;
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (ov !== 1'b0 || sb.size() != 0) $display("[TB] FAIL bp_drained: out_valid=%b pending=%0d, required 0/0", ov, sb.size());
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic fired, rdy, ov;
    logic [33:0] exp, act;
    int bad = 0;
    for (int i = 0; i <= 100; i++) begin
      if (i < 100) drive_cycle(1'b1, 16'($urandom), 2'($urandom_range(0, 3)), 1'b1, fired, exp, act, rdy, ov);
      else         drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
      if (i > 0) begin
        checks++;
        if (!fired || act !== exp) begin
          bad++;
          if (bad <= 5) $display("[TB] FAIL stream_%0d: valid=%b got=%h, required %h", i-1, ov, act, exp);
        end else passes++;
      end
    end
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (ov !== 1'b0 || sb.size() != 0) $display("[TB] FAIL stream_drained: out_valid=%b pending=%0d, required 0/0", ov, sb.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    logic fired, rdy, ov;
    logic [33:0] exp, act;
    drive_cycle(1'b1, 16'h1111, EXT_ZEXT, 1'b0, fired, exp, act, rdy, ov);
    drive_cycle(1'b1, 16'h2222, EXT_ZEXT, 1'b0, fired, exp, act, rdy, ov);
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b0, fired, exp, act, rdy, ov);
    checks++;
    if (rdy !== 1'b0 || ov !== 1'b1) $display("[TB] FAIL rstmid_full: in_ready=%b out_valid=%b, required 0/1", rdy, ov);
    else passes++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus_d.out_valid !== 1'b0 || bus_d.in_ready !== 1'b1 || bus_d.out_data !== 32'h0)
      $display("[TB] FAIL rstmid_async: out_valid=%b in_ready=%b out_data=%h, required 0/1/0", bus_d.out_valid, bus_d.in_ready, bus_d.out_data);
    else passes++;
    #1 rst = 1'b0;
    sb.delete();
    drive_cycle(1'b1, 16'h7FFF, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
    checks++;
    if (!fired || act !== {EXT_SEXT, 32'h00007FFF} || act !== exp)
      $display("[TB] FAIL rstmid_next: valid=%b data=%h, required 1/00007fff", ov, act[31:0]);
    else passes++;
    drive_cycle(1'b0, 16'h0, EXT_SEXT, 1'b1, fired, exp, act, rdy, ov);
  endtask

  task automatic test_param_sweep();
    @(negedge clk);
    bus_s.in_valid  = 1'b1;
    bus_s.in_imm    = 12'h800;
    bus_s.in_mode   = EXT_BRANCH;
    bus_s.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 20'hFF000 || bus_s.out_mode !== EXT_BRANCH)
      $display("[TB] FAIL sweep_branch: valid=%b data=%h mode=%b, required 1/ff000/11", bus_s.out_valid, bus_s.out_data, bus_s.out_mode);
    else passes++;
    bus_s.in_mode = EXT_UPPER;
    @(negedge clk);
    checks++;
    if (bus_s.out_valid !== 1'b1 || bus_s.out_data !== 20'h80000 || bus_s.out_mode !== EXT_UPPER)
      $display("[TB] FAIL sweep_upper: valid=%b data=%h mode=%b, required 1/80000/10", bus_s.out_valid, bus_s.out_data, bus_s.out_mode);
    else passes++;
    bus_s.in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus_d.in_valid  = 1'b0;
    bus_d.in_imm    = '0;
    bus_d.in_mode   = EXT_SEXT;
    bus_d.out_ready = 1'b1;
    bus_s.in_valid  = 1'b0;
    bus_s.in_imm    = '0;
    bus_s.in_mode   = EXT_SEXT;
    bus_s.out_ready = 1'b1;
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_param_sweep();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ext_pipe_unit.md
# ext_pipe_unit

Parametrised, pipelined immediate-extension unit for the multicycle CPU datapath. It generalises the fixed 16→32 sign extender with configurable widths, four extension modes selected per transfer, and a registered valid/ready output stage with a 2-entry skid buffer. It sits between the instruction register and the ALU B-operand mux, so that an immediate can be extended while the ALU consumes an earlier operand.

## Interface
- `IN_W`, default 16: immediate input width; must be ≥ 2.
- `OUT_W`, default 32: output width; must be ≥ `IN_W + BR_SHIFT`.
- `BR_SHIFT`, default 2: left shift applied in branch mode.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  input transfer request.
- `in_ready`  out  1  unit can accept input this cycle.
- `in_imm`  in  `IN_W`  raw immediate.
- `in_mode`  in  2  extension mode.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `out_data`  out  `OUT_W`  extended result.
- `out_mode`  out  2  mode that produced `out_data`.

## Operation
- Extension function, where s = `in_imm[IN_W-1]`:
  - Mode 00 (SEXT): `{(OUT_W-IN_W){s}, in_imm}`.
  - Mode 01 (ZEXT): `{(OUT_W-IN_W){0}, in_imm}`.
  - Mode 10 (UPPER): `in_imm` placed in the top `IN_W` bits, lower `OUT_W-IN_W` bits zero.
  - Mode 11 (BRANCH): the SEXT result shifted left by `BR_SHIFT`, truncated to `OUT_W`. Only sign-copy bits are lost.
- The result is computed combinationally from the input and captured into the pipeline on an input transfer.
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Storage is a main register M, which drives the outputs, and a skid register S, each with its own valid bit.
- Skid-buffer states:
  - EMPTY (M=0, S=0):
    - input transfer → M loaded, go to ONE.
  - ONE (M=1, S=0):
    - input and output transfer together → M reloaded, stay in ONE.
    - input transfer only → S loaded, go to FULL.
    - output transfer only → go to EMPTY.
  - FULL (M=1, S=1):
    - `in_ready` = 0.
    - output transfer → S moves to M, go to ONE.
- `in_ready` = !S_valid. It comes from a register, not combinationally from `out_ready`.
- Results leave in acceptance order. No result is dropped or duplicated.
- `out_data` and `out_mode` stay stable while `out_valid && !out_ready`.
- Reset values: `out_valid` 0, `in_ready` 1, `out_data` 0, `out_mode` 0, both valid bits 0.
- Reset mid-operation discards every held result immediately. The first input transfer after `rst` falls is accepted normally.

## Timing
- Latency: an input transfer in cycle N gives `out_valid` = 1 with that result in cycle N+1, provided M is empty or is transferring out in cycle N.
- Throughput: one result per cycle while `out_ready` stays high.
- Backpressure: after `out_ready` falls, at most 2 further results are held. `in_ready` falls in the cycle after S is loaded.
- When `out_ready` rises in FULL, `in_ready` returns to 1 in the next cycle.
- No combinational path from `in_*` to `out_*`. The only combinational input→output path is none; `in_ready` depends on registers only.
- `rst` clears all state asynchronously. The outputs show the reset values in the same cycle `rst` is asserted.

## Structure
- Shared package `ext_pkg` holds:
  - the mode constants `EXT_SEXT`=2'b00, `EXT_ZEXT`=2'b01, `EXT_UPPER`=2'b10, `EXT_BRANCH`=2'b11;
  - the skid state encoding.
- Sub-module `ext_skid_buf`: generic 2-entry valid/ready skid buffer, parametrised by payload width (`OUT_W+2`).
- The top level holds the extension function and the parameter checks (elaboration error if `OUT_W < IN_W + BR_SHIFT`).

## Test plan
- Default parameters, `out_ready`=1, modes SEXT and ZEXT with `in_imm`=16'h8000 → `out_data` 32'hFFFF8000 then 32'h00008000, each one cycle after acceptance.
- UPPER with 16'h1234 → 32'h12340000. BRANCH with 16'hFFFF → 32'hFFFFFFFC. BRANCH with 16'h0001 → 32'h00000004.
- Backpressure: hold `out_ready`=0 and offer 16'h0001, 16'h0002, 16'h0003 with SEXT on consecutive cycles.
  - Only the first two are accepted; `in_ready`=0 from the cycle after the second acceptance.
  - Release `out_ready` → outputs 1, 2, 3 in order, with 3 accepted once `in_ready` returns.
- Streaming: 100 back-to-back random transfers with `out_ready`=1 → 100 results in 100 consecutive cycles, each matching the reference model.
- Reset mid-operation: in FULL, pulse `rst` for part of a cycle → `out_valid`=0 and `in_ready`=1 immediately. The next transfer (16'h7FFF, SEXT) yields 32'h00007FFF.
- Parameter sweep: `IN_W`=12, `OUT_W`=20, `BR_SHIFT`=1 with 12'h800 in BRANCH → 20'hFF000. The same input in UPPER → 20'h80000.
